// File: rtl/care_action_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : care_action_ctrl
// Purpose  : Button front-end for the stats block. Synchronises and debounces
//            four raw buttons, runs a browse/confirm menu over six care
//            actions and emits one single-cycle one-hot action pulse per
//            confirmed action, followed by a cooldown.
// Ports    : clk        - system clock (rising edge)
//            reset      - synchronous active-high reset
//            btn_next   - raw button, asynchronous, active-high
//            btn_prev   - raw button, asynchronous, active-high
//            btn_ok     - raw button, asynchronous, active-high
//            btn_cancel - raw button, asynchronous, active-high
//            inputs     - one-hot action pulse (bits 7:6 always 0)
//            cursor     - highlighted action 0..5
//            state_o    - 0 IDLE, 1 CONFIRM, 2 FIRE, 3 COOLDOWN
//            busy       - high in FIRE and COOLDOWN
// Revision : 1.0 - initial release
// ============================================================================
module care_action_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COOLDOWN_CYCLES = 16,
    parameter int CONFIRM_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_ok,
    input  logic       btn_cancel,
    output logic [7:0] inputs,
    output logic [2:0] cursor,
    output logic [1:0] state_o,
    output logic       busy
);

    localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_CD_W = $clog2(COOLDOWN_CYCLES + 1);
    localparam int c_TO_W = $clog2(CONFIRM_TIMEOUT + 1);

    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CD_W-1:0] c_CD_LAST = c_CD_W'(COOLDOWN_CYCLES - 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(CONFIRM_TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_CONFIRM  = 2'd1;
    localparam logic [1:0] c_ST_FIRE     = 2'd2;
    localparam logic [1:0] c_ST_COOLDOWN = 2'd3;

    localparam int c_NEXT   = 0;
    localparam int c_PREV   = 1;
    localparam int c_OK     = 2;
    localparam int c_CANCEL = 3;

    logic [3:0] w_btn_raw;
    logic [3:0] w_evt;

    assign w_btn_raw = {btn_cancel, btn_ok, btn_prev, btn_next};

    // ------------------------------------------------------------------------
    // Per-button conditioning: 2-flop synchroniser, debouncer, press edge.
    // The press event is registered alongside the debounced level, so it is
    // high for exactly the first cycle in which the debounced level is 1.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        logic [1:0]        sync_q, sync_d;
        logic              deb_q, deb_d;
        logic              evt_q, evt_d;
        logic [c_DB_W-1:0] cnt_q, cnt_d;

        always_comb begin
            sync_d = {sync_q[0], w_btn_raw[gi]};
            deb_d  = deb_q;
            cnt_d  = '0;
            evt_d  = 1'b0;
            if (sync_q[1] != deb_q) begin
                if (cnt_q == c_DB_LAST) begin
                    deb_d = sync_q[1];
                    evt_d = sync_q[1];   // rising edges only
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                sync_q <= '0;
                deb_q  <= 1'b0;
                evt_q  <= 1'b0;
                cnt_q  <= '0;
            end else begin
                sync_q <= sync_d;
                deb_q  <= deb_d;
                evt_q  <= evt_d;
                cnt_q  <= cnt_d;
            end
        end

        assign w_evt[gi] = evt_q;
    end

    // Priority resolution: cancel > ok > next > prev, one event per cycle.
    logic w_ev_cancel, w_ev_ok, w_ev_next, w_ev_prev;

    assign w_ev_cancel = w_evt[c_CANCEL];
    assign w_ev_ok     = w_evt[c_OK]   & ~w_evt[c_CANCEL];
    assign w_ev_next   = w_evt[c_NEXT] & ~w_evt[c_OK] & ~w_evt[c_CANCEL];
    assign w_ev_prev   = w_evt[c_PREV] & ~w_evt[c_NEXT] & ~w_evt[c_OK]
                       & ~w_evt[c_CANCEL];

    // ------------------------------------------------------------------------
    // Menu FSM
    // ------------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [2:0]        cursor_q, cursor_d;
    logic [c_TO_W-1:0] tmo_q, tmo_d;
    logic [c_CD_W-1:0] cd_q, cd_d;
    logic [7:0]        inputs_q, inputs_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= c_ST_IDLE;
            cursor_q <= 3'd0;
            tmo_q    <= '0;
            cd_q     <= '0;
            inputs_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            tmo_q    <= tmo_d;
            cd_q     <= cd_d;
            inputs_q <= inputs_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        tmo_d    = tmo_q;
        cd_d     = cd_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_ev_ok) begin
                    state_d = c_ST_CONFIRM;
                    tmo_d   = '0;
                end else if (w_ev_next) begin
                    cursor_d = (cursor_q == 3'd5) ? 3'd0 : cursor_q + 3'd1;
                end else if (w_ev_prev) begin
                    cursor_d = (cursor_q == 3'd0) ? 3'd5 : cursor_q - 3'd1;
                end
            end
            c_ST_CONFIRM: begin
                // ok outranks the timeout when both land in the same cycle
                if (w_ev_cancel) begin
                    state_d = c_ST_IDLE;
                end else if (w_ev_ok) begin
                    state_d = c_ST_FIRE;
                end else if (tmo_q == c_TO_LAST) begin
                    state_d = c_ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            c_ST_FIRE: begin
                state_d = c_ST_COOLDOWN;
                cd_d    = '0;
            end
            c_ST_COOLDOWN: begin
                // press events are dropped here, not queued
                if (cd_q == c_CD_LAST) begin
                    state_d = c_ST_IDLE;
                end else begin
                    cd_d = cd_q + 1'b1;
                end
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    // Output logic: the pulse is registered on entry to FIRE so that it is
    // visible exactly during the FIRE cycle.
    always_comb begin
        inputs_d = 8'h00;
        if (state_d == c_ST_FIRE) begin
            inputs_d = 8'h01 << cursor_q;
        end
    end

    assign inputs  = inputs_q;
    assign cursor  = cursor_q;
    assign state_o = state_q;
    assign busy    = (state_q == c_ST_FIRE) || (state_q == c_ST_COOLDOWN);

endmodule
`default_nettype wire
